// File: rtl/twiddle_angle_sequencer.sv
// twiddle_angle_sequencer
// Walks one frame of 2^ADDR_W butterflies, reads the per-stage twiddle-angle
// ROM (one-cycle registered read) and presents (butterfly index, angle) pairs
// to the CORDIC rotator through a 2-entry valid/ready output buffer.
// Optional build macro: SEQ_INVERSE_EN adds i_inverse, which makes every
// non-zero angle positive (sign flip) for the inverse transform.
module twiddle_angle_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_group_log,
`ifdef SEQ_INVERSE_EN
  input  logic              i_inverse,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_angle,
  output logic [ADDR_W-1:0] o_bf_idx,
  output logic              o_valid,
  input  logic              i_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]          g_reg, g_next;
  logic [2:0]          g_clamp;
  logic [ADDR_W-1:0]   grp_mask;
  logic                inflight_reg;
  logic [ADDR_W-1:0]   inflight_idx_reg;
  logic [1:0]          count_reg;
  logic [DATA_W-1:0]   head_angle_reg, tail_angle_reg;
  logic [ADDR_W-1:0]   head_idx_reg, tail_idx_reg;
  logic [DATA_W-1:0]   angle_in;
  logic [2:0]          occupancy;
  logic                issue, done, push, pop;

  // Group size is clamped so the mask never exceeds the frame width.
  assign g_clamp  = (i_group_log > 3'(ADDR_W)) ? 3'(ADDR_W) : i_group_log;
  assign grp_mask = ADDR_W'((1 << g_reg) - 1);

  // Address walks the low g bits of the counter, MSB-aligned in the ROM.
  assign o_rom_addr = (cnt_reg & grp_mask) << (ADDR_W - int'(g_reg));

  assign push    = inflight_reg;
  assign o_valid = (count_reg != 2'd0);
  assign pop     = o_valid & i_ready;

  // Slots already committed: buffered + in flight, minus what leaves this cycle.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  assign o_busy   = (state_reg != IDLE);
  assign o_done   = done;
  assign o_angle  = head_angle_reg;
  assign o_bf_idx = head_idx_reg;

`ifdef SEQ_INVERSE_EN
  logic inv_reg;

  // Inverse-mode flag is captured together with the group size at start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      inv_reg <= 1'b0;
    else if (state_reg == IDLE && i_start)
      inv_reg <= i_inverse;
  end

  // Zero keeps its +0.0 encoding; everything else gets its sign flipped.
  assign angle_in = (inv_reg && (i_rom_data != '0)) ?
                    {~i_rom_data[DATA_W-1], i_rom_data[DATA_W-2:0]} : i_rom_data;
`else
  assign angle_in = i_rom_data;
`endif

  // State, frame counter and latched group size.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      g_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      g_reg     <= g_next;
    end
  end

  // Next-state logic: issue reads while buffer space is guaranteed, then drain.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    g_next     = g_reg;
    issue      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          g_next     = g_clamp;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (occupancy < 3'(BUF_DEPTH)) begin
          issue    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == '1)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count_reg == 2'd0 && !inflight_reg) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tracks the read whose data arrives from the ROM in the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_reg     <= 1'b0;
      inflight_idx_reg <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue)
        inflight_idx_reg <= cnt_reg;
    end
  end

  // Two-entry FIFO as head/tail registers so the head holds its value when empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg      <= 2'd0;
      head_angle_reg <= '0;
      head_idx_reg   <= '0;
      tail_angle_reg <= '0;
      tail_idx_reg   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_angle_reg <= angle_in;
            head_idx_reg   <= inflight_idx_reg;
          end else begin
            tail_angle_reg <= angle_in;
            tail_idx_reg   <= inflight_idx_reg;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) begin
            head_angle_reg <= tail_angle_reg;
            head_idx_reg   <= tail_idx_reg;
          end
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_angle_reg <= angle_in;
            head_idx_reg   <= inflight_idx_reg;
          end else begin
            head_angle_reg <= tail_angle_reg;
            head_idx_reg   <= tail_idx_reg;
            tail_angle_reg <= angle_in;
            tail_idx_reg   <= inflight_idx_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_angle_sequencer.sv
// tb_twiddle_angle_sequencer
// Scoreboard bench: a ROM model answers o_rom_addr one cycle later, each start
// pushes the 64 expected (bf_idx, angle) pairs, and the output monitor pops and
// compares on every handshake. Frame timing and reset behaviour are also checked.
module tb_twiddle_angle_sequencer;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NBF    = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] angle;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        group_log = 3'd0;
  logic              ready = 1'b0;
  logic              busy, done, valid;
  logic [ADDR_W-1:0] rom_addr, bf_idx;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] angle;
`ifdef SEQ_INVERSE_EN
  logic              inverse = 1'b0;
`endif

  logic [DATA_W-1:0] rom_tbl [NBF];
  exp_t              sb_q[$];
  exp_t              mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mon_rel;
  int hs_cnt, done_cnt, first_valid_rel, last_hs_rel, done_rel, busy_fall_rel;
  int cur_g;
  logic cur_inv;

  twiddle_angle_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_group_log (group_log),
`ifdef SEQ_INVERSE_EN
    .i_inverse   (inverse),
`endif
    .o_busy      (busy),
    .o_done      (done),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_angle     (angle),
    .o_bf_idx    (bf_idx),
    .o_valid     (valid),
    .i_ready     (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered read, one cycle of latency.
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-to-nearest-even conversion of a normal double to single precision.
  function automatic logic [31:0] to_single(input real r);
    logic [63:0] b;
    logic [23:0] mr;
    int          ex;
    if (r == 0.0) return 32'h0;
    b  = $realtobits(r);
    mr = {1'b0, b[51:29]};
    if (b[28] && ((|b[27:0]) || b[29])) mr = mr + 24'd1;
    ex = int'(b[62:52]) - 1023 + 127;
    if (mr[23]) begin
      ex++;
      mr = '0;
    end
    return {b[63], ex[7:0], mr[22:0]};
  endfunction

  // Output monitor: pops the scoreboard on each handshake, records frame timing.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_rel = cyc - start_cyc;
      if (valid && first_valid_rel < 0) first_valid_rel = mon_rel;
      if (valid && ready) begin
        hs_cnt++;
        last_hs_rel = mon_rel;
        if (sb_q.size() == 0) begin
          check("extra_output", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("bf_idx", 64'(bf_idx), 64'(mon_e.idx));
          check("angle", 64'(angle), 64'(mon_e.angle));
          if (cur_g == 6) begin
            if (bf_idx == 6'd0) check("angle_bf0_lit", 64'(angle), 64'h0);
            if (bf_idx == 6'd1)
              check("angle_bf1_lit", 64'(angle), cur_inv ? 64'h3d490fdb : 64'hbd490fdb);
            if (bf_idx == 6'd2 && !cur_inv) check("angle_bf2_lit", 64'(angle), 64'hbdc90fdb);
            if (bf_idx == 6'd63)
              check("angle_bf63_lit", 64'(angle), cur_inv ? 64'h4045eb9b : 64'hc045eb9b);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = mon_rel;
        check("busy_at_done", 64'(busy), 64'd1);
      end
      if (done_cnt > 0 && !busy && busy_fall_rel < 0) busy_fall_rel = mon_rel;
    end
  end

  task automatic drive_ready(input int mode, input int rel);
    if (mode == 0) ready = 1'b1;
    else if (rel >= 20 && rel < 30) ready = 1'b0;
    else ready = ((rel % 4) == 0) || ((rel % 4) == 3);
  endtask

  // Push expectations for one frame and pulse start (called at posedge + 1).
  task automatic launch(input logic [2:0] gl, input logic inv, input int mode);
    int g;
    int a_idx;
    logic [DATA_W-1:0] a;
    logic [ADDR_W-1:0] k6;
    g = (gl > 3'd6) ? 6 : int'(gl);
    for (int k = 0; k < NBF; k++) begin
      a_idx = ((k & ((1 << g) - 1)) << (6 - g)) & 63;
      a = rom_tbl[a_idx];
      if (inv && a != 32'h0) a[31] = ~a[31];
      k6 = k[5:0];
      sb_q.push_back({k6, a});
    end
    hs_cnt = 0; done_cnt = 0; first_valid_rel = -1; last_hs_rel = -1;
    done_rel = -1; busy_fall_rel = -1; cur_g = g; cur_inv = inv;
    group_log = gl;
`ifdef SEQ_INVERSE_EN
    inverse = inv;
`endif
    start = 1'b1;
    start_cyc = cyc;
    drive_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [2:0] gl, input logic inv, input int mode);
    int n;
    launch(gl, inv, mode);
    n = 0;
    while (busy_fall_rel < 0 && n < 1000) begin
      drive_ready(mode, cyc - start_cyc);
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, 64'(n < 1000), 64'd1);
    check({name, "_hs_count"}, 64'(hs_cnt), 64'(NBF));
    check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_done_after_last"}, 64'(done_rel), 64'(last_hs_rel + 1));
    if (mode == 0) begin
      check({name, "_first_valid_cyc"}, 64'(first_valid_rel), 64'd3);
      check({name, "_last_hs_cyc"}, 64'(last_hs_rel), 64'd66);
      check({name, "_done_cyc"}, 64'(done_rel), 64'd67);
      check({name, "_busy_fall_cyc"}, 64'(busy_fall_rel), 64'd68);
    end
    sb_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_valid"}, 64'(valid), 64'd0);
    check({name, "_angle"}, 64'(angle), 64'd0);
    check({name, "_bf_idx"}, 64'(bf_idx), 64'd0);
    check({name, "_rom_addr"}, 64'(rom_addr), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NBF; k++)
      rom_tbl[k] = to_single(-(real'(k)) * 3.14159265358979323846 / 64.0);
    hs_cnt = 0; done_cnt = 0; first_valid_rel = -1; last_hs_rel = -1;
    done_rel = -1; busy_fall_rel = -1; cur_g = 0; cur_inv = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("g6", 3'd6, 1'b0, 0);
    run_frame("g1", 3'd1, 1'b0, 0);
    run_frame("g7_clamp", 3'd7, 1'b0, 0);
    run_frame("g0", 3'd0, 1'b0, 0);
    run_frame("g6_stall", 3'd6, 1'b0, 1);

    // Mid-frame restart attempt, then asynchronous reset at bf_idx 20.
    launch(3'd6, 1'b0, 0);
    n = 0;
    while (hs_cnt < 21 && n < 300) begin
      ready = 1'b1;
      if (cyc - start_cyc == 5) begin
        group_log = 3'd0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("abort_reach_bf20", 64'(hs_cnt), 64'd21);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort_reset");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");
    run_frame("replay", 3'd6, 1'b0, 0);

`ifdef SEQ_INVERSE_EN
    run_frame("inverse", 3'd6, 1'b1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
